// File: rtl/apb_master_ctrl.sv
// rtl/apb_master_ctrl.sv - APB3 initiator: one valid/ready command becomes one APB transfer with a held response
//
// Ports:
//   PCLK, PRESET_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake (cmd_ready decodes IDLE)
//   cmd_write, cmd_addr, cmd_wdata command fields, latched on acceptance
//   rsp_valid/rsp_ready            response handshake, rsp_valid held until rsp_ready
//   rsp_rdata, rsp_err, rsp_timeout response fields, stable while rsp_valid
//   PSEL, PENABLE, PWRITE, PADDR,
//   PWDATA, PRDATA, PREADY, PSLVERR APB3 initiator interface

module apb_master_ctrl #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    // Keep the wait counter at least one bit wide when the timeout is disabled.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] wait_q;
    logic [CNT_W-1:0] wait_d;

    // Value the wait counter would take on this edge; the abort fires when it
    // lands on TIMEOUT_CYCLES, so the slave gets exactly that many unready edges.
    assign wait_d    = wait_q + CNT_W'(1);
    assign cmd_ready = (state_q == IDLE);

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        state_q <= SETUP;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        PWRITE  <= cmd_write;
                        PADDR   <= cmd_addr;
                        PWDATA  <= cmd_write ? cmd_wdata : '0;
                    end
                end
                SETUP: begin
                    state_q <= ACCESS;
                    PENABLE <= 1'b1;
                    wait_q  <= '0;
                end
                ACCESS: begin
                    // PREADY wins over a timeout landing on the same edge.
                    if (PREADY) begin
                        state_q     <= RESP;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        PWRITE      <= 1'b0;
                        PADDR       <= '0;
                        PWDATA      <= '0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                    end else if ((TIMEOUT_CYCLES != 0) && (wait_d == TO_VAL)) begin
                        state_q     <= RESP;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        PWRITE      <= 1'b0;
                        PADDR       <= '0;
                        PWDATA      <= '0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        wait_q <= wait_d;
                    end
                end
                RESP: begin
                    // Response fields are left as-is so they remain readable after the handshake.
                    if (rsp_ready) begin
                        state_q   <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb/tb_apb_master_ctrl.sv - directed self-checking bench for apb_master_ctrl

module tb_apb_master_ctrl;

    logic       PCLK;
    logic       PRESET_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rsp_timeout;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;

    int tests;
    int failures;
    int n_en;
    int n_cyc;

    apb_master_ctrl #(
        .ADDR_WIDTH     (8),
        .DATA_WIDTH     (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .PCLK        (PCLK),
        .PRESET_n    (PRESET_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests     = 0;
        failures  = 0;
        PRESET_n  = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'h00;
        cmd_wdata = 8'h00;
        rsp_ready = 1'b1;
        PRDATA    = 8'h00;
        PREADY    = 1'b1;
        PSLVERR   = 1'b0;
        repeat (2) tick();
        PRESET_n = 1'b1;
        tick();

        // Reset state
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_pwrite", PWRITE, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_pwdata", PWDATA, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);

        // 1: zero-wait write 0x5A to 0x00
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h00; cmd_wdata = 8'h5A;
        PREADY = 1'b1; PSLVERR = 1'b0;
        tick(); // E0
        cmd_valid = 1'b0;
        check("w0_setup_psel", PSEL, 1);
        check("w0_setup_penable", PENABLE, 0);
        check("w0_setup_pwrite", PWRITE, 1);
        check("w0_setup_paddr", PADDR, 8'h00);
        check("w0_setup_pwdata", PWDATA, 8'h5A);
        check("w0_setup_cmd_ready", cmd_ready, 0);
        check("w0_setup_rsp_valid", rsp_valid, 0);
        tick(); // E1
        check("w0_access_psel", PSEL, 1);
        check("w0_access_penable", PENABLE, 1);
        check("w0_access_pwdata", PWDATA, 8'h5A);
        tick(); // E2
        check("w0_done_psel", PSEL, 0);
        check("w0_done_penable", PENABLE, 0);
        check("w0_done_pwdata", PWDATA, 0);
        check("w0_rsp_valid", rsp_valid, 1);
        check("w0_rsp_err", rsp_err, 0);
        check("w0_rsp_rdata", rsp_rdata, 0);
        check("w0_rsp_timeout", rsp_timeout, 0);
        tick(); // E3
        check("w0_rsp_cleared", rsp_valid, 0);
        check("w0_back_idle", cmd_ready, 1);

        // 2: read 0x02 with three wait states, PRDATA 0xC3
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h02; cmd_wdata = 8'hAA;
        PREADY = 1'b0;
        tick(); // E0
        cmd_valid = 1'b0;
        check("r2_setup_psel", PSEL, 1);
        check("r2_setup_pwrite", PWRITE, 0);
        check("r2_setup_pwdata_zero", PWDATA, 0);
        n_en = 0;
        tick(); // E1
        if (PENABLE) n_en++;
        check("r2_paddr_e1", PADDR, 8'h02);
        tick(); // E2
        if (PENABLE) n_en++;
        check("r2_paddr_e2", PADDR, 8'h02);
        tick(); // E3
        if (PENABLE) n_en++;
        check("r2_paddr_e3", PADDR, 8'h02);
        tick(); // E4
        if (PENABLE) n_en++;
        check("r2_paddr_e4", PADDR, 8'h02);
        check("r2_rsp_not_yet", rsp_valid, 0);
        PREADY = 1'b1; PRDATA = 8'hC3;
        tick(); // E5
        check("r2_penable_cycles", n_en, 4);
        check("r2_rsp_valid", rsp_valid, 1);
        check("r2_rsp_rdata", rsp_rdata, 8'hC3);
        check("r2_rsp_err", rsp_err, 0);
        check("r2_psel_low", PSEL, 0);
        PRDATA = 8'h00;
        tick();

        // 3: write 0xFF with slave error, then a normal command
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'hFF; cmd_wdata = 8'h11;
        PREADY = 1'b1; PSLVERR = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("e3_setup_paddr", PADDR, 8'hFF);
        tick();
        tick();
        check("e3_rsp_valid", rsp_valid, 1);
        check("e3_rsp_err", rsp_err, 1);
        check("e3_rsp_timeout", rsp_timeout, 0);
        PSLVERR = 1'b0;
        tick();
        check("e3_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h01; cmd_wdata = 8'h22;
        tick();
        cmd_valid = 1'b0;
        check("e3_next_psel", PSEL, 1);
        check("e3_next_pwdata", PWDATA, 8'h22);
        tick();
        tick();
        check("e3_next_rsp_valid", rsp_valid, 1);
        check("e3_next_rsp_err", rsp_err, 0);
        tick();

        // 4: slave never ready, timeout after 16 ACCESS cycles
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h03; cmd_wdata = 8'h00;
        PREADY = 1'b0; PRDATA = 8'h99; PSLVERR = 1'b1;
        tick(); // E0
        cmd_valid = 1'b0;
        tick(); // E1
        n_en = 0;
        n_cyc = 0;
        while (!rsp_valid && n_cyc < 40) begin
            if (PENABLE) n_en++;
            n_cyc++;
            tick();
        end
        check("to_rsp_seen", rsp_valid, 1);
        check("to_penable_cycles", n_en, 16);
        check("to_psel", PSEL, 0);
        check("to_penable", PENABLE, 0);
        check("to_rsp_err", rsp_err, 1);
        check("to_rsp_timeout", rsp_timeout, 1);
        check("to_rsp_rdata", rsp_rdata, 0);
        PSLVERR = 1'b0; PRDATA = 8'h00; PREADY = 1'b1;
        tick();
        check("to_idle", cmd_ready, 1);

        // 5: response back-pressure with a pending command
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h04;
        rsp_ready = 1'b0; PRDATA = 8'h7E;
        tick();
        cmd_write = 1'b1; cmd_addr = 8'h10; cmd_wdata = 8'h33; // next command held
        tick();
        tick();
        PRDATA = 8'h00;
        check("bp_rsp_valid", rsp_valid, 1);
        check("bp_rsp_rdata", rsp_rdata, 8'h7E);
        check("bp_rsp_timeout_clr", rsp_timeout, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", rsp_valid, 1);
            check("bp_hold_rdata", rsp_rdata, 8'h7E);
            check("bp_hold_cmd_ready", cmd_ready, 0);
            check("bp_hold_psel", PSEL, 0);
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_released", rsp_valid, 0);
        check("bp_rdata_kept", rsp_rdata, 8'h7E);
        check("bp_idle", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("bp_next_psel", PSEL, 1);
        check("bp_next_paddr", PADDR, 8'h10);
        check("bp_next_pwdata", PWDATA, 8'h33);
        tick();
        tick();
        check("bp_next_rsp", rsp_valid, 1);
        check("bp_next_rdata", rsp_rdata, 0);
        tick();

        // 6: reset during ACCESS
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h05;
        PREADY = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("rs_in_access", PENABLE, 1);
        #2;
        PRESET_n = 1'b0;
        #1;
        check("rs_psel", PSEL, 0);
        check("rs_penable", PENABLE, 0);
        check("rs_paddr", PADDR, 0);
        check("rs_rsp_valid", rsp_valid, 0);
        tick();
        PRESET_n = 1'b1;
        PREADY = 1'b1;
        check("rs_cmd_ready", cmd_ready, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rs_no_rsp", rsp_valid, 0);
            check("rs_no_psel", PSEL, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    // Watchdog: the directed sequence is short, so anything this long is a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
